// File: rtl/lfsr_pkg.sv
// Shared PRBS definitions used by the lfsr generator and checker.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SYNC_SEARCH = 2'd0,
        SYNC_LOCKED = 2'd1
    } sync_state_t;

    // Operands are zero-extended by callers, so one function serves any WIDTH up to 32.
    function automatic logic lfsr_feedback(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_predictor.sv
// Combinational next-bit prediction from the receive history and tap mask.
module lfsr_predictor
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] hist,
    input  logic [WIDTH-1:0] taps,
    output logic             pred
);

    assign pred = lfsr_feedback(32'(hist), 32'(taps));

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-synchronises to an lfsr stream, locks, then counts bit errors.
//   state       | meaning
//   SYNC_SEARCH | filling history from received bits, counting consecutive correct predictions
//   SYNC_LOCKED | flywheeling on predicted bits, flagging mismatches as errors
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int LOCK_COUNT  = 8,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic [WIDTH-1:0]     taps,
    input  logic                 resync,
    input  logic                 clear_errors,
    output logic                 locked,
    output logic                 bit_error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           sync_state
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

    sync_state_t          state, state_nx;
    logic [WIDTH-1:0]     hist, hist_nx;
    logic [FILL_W-1:0]    fill, fill_nx;
    logic [MATCH_W-1:0]   match_cnt, match_nx;
    logic [MISS_W-1:0]    miss_cnt, miss_nx;
    logic                 err_nx;
    logic                 pred;

    lfsr_predictor #(.WIDTH(WIDTH)) u_predictor (
        .hist (hist),
        .taps (taps),
        .pred (pred)
    );

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill;
        match_nx = match_cnt;
        miss_nx  = miss_cnt;
        err_nx   = 1'b0;

        if (in_valid) begin
            case (state)
                SYNC_SEARCH: begin
                    hist_nx = {hist[WIDTH-2:0], in_bit};
                    if (fill != FILL_FULL) begin
                        fill_nx = fill + 1'b1;
                    end else if ((in_bit == pred) && (hist != '0)) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nx = SYNC_LOCKED;
                            match_nx = '0;
                            miss_nx  = '0;
                        end else begin
                            match_nx = match_cnt + 1'b1;
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                SYNC_LOCKED: begin
                    // Flywheel on the prediction so a corrupted bit never enters the history.
                    hist_nx = {hist[WIDTH-2:0], pred};
                    if (in_bit != pred) begin
                        err_nx = 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            state_nx = SYNC_SEARCH;
                            fill_nx  = '0;
                            match_nx = '0;
                            miss_nx  = '0;
                        end else begin
                            miss_nx = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_nx = '0;
                    end
                end
                default: state_nx = SYNC_SEARCH;
            endcase
        end

        if (resync) begin
            state_nx = SYNC_SEARCH;
            fill_nx  = '0;
            match_nx = '0;
            miss_nx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SYNC_SEARCH;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            bit_error <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill      <= fill_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            locked    <= (state_nx == SYNC_LOCKED);
            bit_error <= err_nx;
            if (clear_errors) begin
                err_count <= '0;
            end else if (err_nx && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign sync_state = state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed PRBS scenarios against 16-bit and 3-bit counters.
module tb_lfsr_checker;

    localparam logic [4:0] TAPS = 5'b10100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic [4:0]  taps = TAPS;
    logic        resync = 1'b0;
    logic        clear_errors = 1'b0;

    logic        locked_a, bit_error_a, locked_b, bit_error_b;
    logic [15:0] err_count_a;
    logic [2:0]  err_count_b;
    logic [1:0]  sync_state_a, sync_state_b;

    lfsr_checker #(.WIDTH(5), .LOCK_COUNT(8), .LOSS_THRESH(4), .ERR_CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .taps(taps),
        .resync(resync), .clear_errors(clear_errors), .locked(locked_a),
        .bit_error(bit_error_a), .err_count(err_count_a), .sync_state(sync_state_a)
    );

    lfsr_checker #(.WIDTH(5), .LOCK_COUNT(8), .LOSS_THRESH(4), .ERR_CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .taps(taps),
        .resync(resync), .clear_errors(clear_errors), .locked(locked_b),
        .bit_error(bit_error_b), .err_count(err_count_b), .sync_state(sync_state_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          phase;
        logic        locked;
        logic        berr;
        logic [15:0] cnt16;
        logic [2:0]  cnt3;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          phase = 0;
    logic [4:0]  gen_state = 5'b00001;
    logic [15:0] m_cnt16 = '0;
    logic [2:0]  m_cnt3 = '0;
    logic        cur_locked = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gen_next();
        logic b;
        b = ^(gen_state & TAPS);
        gen_state = {gen_state[3:0], b};
        return b;
    endfunction

    task automatic check(input string name, input int ph, input logic [15:0] act,
                         input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s phase=%0d cyc=%0d actual=%0h required=%0h", name, ph, cyc, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("locked_a",     e.phase, 16'(locked_a),     16'(e.locked));
                check("bit_error_a",  e.phase, 16'(bit_error_a),  16'(e.berr));
                check("err_count_a",  e.phase, err_count_a,       e.cnt16);
                check("sync_state_a", e.phase, 16'(sync_state_a), 16'(e.locked));
                check("locked_b",     e.phase, 16'(locked_b),     16'(e.locked));
                check("bit_error_b",  e.phase, 16'(bit_error_b),  16'(e.berr));
                check("err_count_b",  e.phase, 16'(err_count_b),  16'(e.cnt3));
            end
        end
    end

    // Applies one cycle of inputs and queues the outputs expected after the following edge.
    task automatic step(input logic v, input logic b, input logic exp_l, input logic exp_e,
                        input logic clr = 1'b0, input logic rs = 1'b0, input logic rstn = 1'b1);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid     = v;
        in_bit       = b;
        clear_errors = clr;
        resync       = rs;
        rst_n        = rstn;
        if (!rstn || clr) begin
            m_cnt16 = '0;
            m_cnt3  = '0;
        end else if (exp_e) begin
            if (m_cnt16 != 16'hffff) m_cnt16 = m_cnt16 + 1'b1;
            if (m_cnt3 != 3'h7) m_cnt3 = m_cnt3 + 1'b1;
        end
        cur_locked = exp_l;
        e.due    = cyc + 1;
        e.phase  = phase;
        e.locked = exp_l;
        e.berr   = exp_e;
        e.cnt16  = m_cnt16;
        e.cnt3   = m_cnt3;
        sb.push_back(e);
    endtask

    task automatic clean(input logic exp_l, input logic clr = 1'b0);
        step(1'b1, gen_next(), exp_l, 1'b0, clr);
    endtask

    task automatic corrupt(input logic exp_l, input logic clr = 1'b0);
        step(1'b1, ~gen_next(), exp_l, 1'b1, clr);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, cur_locked, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        phase = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean stream: 5 fill bits then 8 matches, lock seen after bit 13.
        phase = 1;
        for (int k = 1; k <= 200; k++) clean(k >= 13);

        phase = 2;
        corrupt(1'b1);
        for (int k = 0; k < 20; k++) clean(1'b1);

        // Four consecutive errors drop lock; relock counts valid bits only across idle gaps.
        phase = 3;
        clean(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) corrupt(i < 3);
        for (int j = 1; j <= 13; j++) begin
            clean(j >= 13);
            if (j == 4 || j == 9) repeat (3) idle();
        end
        for (int k = 0; k < 5; k++) clean(1'b1);

        phase = 5;
        clean(1'b1, 1'b1);
        for (int n = 0; n < 10; n++) begin
            corrupt(1'b1);
            repeat (3) clean(1'b1);
        end
        corrupt(1'b1, 1'b1);
        clean(1'b1);
        idle();

        phase = 6;
        step(1'b1, gen_next(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 13; j++) clean(j >= 13);
        corrupt(1'b1);
        clean(1'b1);
        corrupt(1'b1);
        clean(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        for (int j = 1; j <= 13; j++) clean(j >= 13);

        // All-zero stream from SEARCH must never lock.
        phase = 4;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 100; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        repeat (4) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
